// File: rtl/plab2_proc_shared_mul_arbiter_pkg.sv
// plab2_proc_shared_mul_arbiter_pkg: shared state encoding and multiplier message widths
package plab2_proc_shared_mul_arbiter_pkg;
    typedef enum logic {STATE_IDLE = 1'b0, STATE_BUSY = 1'b1} state_t;
    localparam int MUL_FUNC_NBITS = 3;
    localparam int MUL_DATA_NBITS = 32;
    localparam int MUL_MSG_NBITS  = MUL_FUNC_NBITS + 2 * MUL_DATA_NBITS;
    function automatic int idx_nbits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/plab2_proc_shared_mul_arbiter_rr_arbiter.sv
// plab2_proc_rr_arbiter: round-robin grant starting at a registered priority pointer
module plab2_proc_rr_arbiter
    import plab2_proc_shared_mul_arbiter_pkg::*;
#(
    parameter int p_num_reqs = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [p_num_reqs-1:0]                reqs,
    input  logic                                 en,
    output logic [p_num_reqs-1:0]                grant,
    output logic [idx_nbits(p_num_reqs)-1:0]     grant_idx
);
    localparam int W = idx_nbits(p_num_reqs);
    logic [W-1:0] ptr;
    logic [W-1:0] j;
    always_comb begin
        grant_idx = '0;
        j = '0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % p_num_reqs);
            grant_idx = reqs[j] ? j : grant_idx;
        end
        grant = |reqs ? p_num_reqs'(1) << grant_idx : '0;
    end
    always_ff @(posedge clk)
        if (reset) ptr <= '0;
        else if (en) ptr <= grant_idx == W'(p_num_reqs - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/plab2_proc_shared_mul_arbiter.sv
// plab2_proc_shared_mul_arbiter: shares one iterative multiplier among cores, one op in flight
module plab2_proc_shared_mul_arbiter
    import plab2_proc_shared_mul_arbiter_pkg::*;
#(
    parameter int p_num_reqs   = 4,
    parameter int p_msg_nbits  = MUL_MSG_NBITS,
    parameter int p_data_nbits = MUL_DATA_NBITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             req_val,
    output logic [p_num_reqs-1:0]             req_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] req_msg,
    output logic [p_num_reqs-1:0]             resp_val,
    input  logic [p_num_reqs-1:0]             resp_rdy,
    output logic [p_data_nbits-1:0]           resp_msg,
    output logic                              mul_in_val,
    input  logic                              mul_in_rdy,
    output logic [p_msg_nbits-1:0]            mul_in_msg,
    input  logic                              mul_out_val,
    output logic                              mul_out_rdy,
    input  logic [p_data_nbits-1:0]           mul_out_msg,
    output logic                              busy,
    output logic [idx_nbits(p_num_reqs)-1:0]  owner
);
    localparam int W = idx_nbits(p_num_reqs);
    state_t state;
    logic idle, active, issue_fire, resp_fire;
    logic [p_num_reqs-1:0] grant;
    logic [W-1:0] grant_idx;
    logic [p_msg_nbits-1:0] msgs [p_num_reqs];

    for (genvar i = 0; i < p_num_reqs; i++) begin : g_msg
        assign msgs[i] = req_msg[i*p_msg_nbits +: p_msg_nbits];
    end

    plab2_proc_rr_arbiter #(.p_num_reqs(p_num_reqs)) arb (
        .clk       (clk),
        .reset     (reset),
        .reqs      (req_val),
        .en        (issue_fire),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign idle        = !reset && state == STATE_IDLE;
    assign active      = !reset && state == STATE_BUSY;
    assign mul_in_val  = idle && |req_val;
    assign mul_in_msg  = msgs[grant_idx];
    assign req_rdy     = idle && mul_in_rdy ? grant : '0;
    assign issue_fire  = mul_in_val && mul_in_rdy;
    assign resp_val    = active ? p_num_reqs'(mul_out_val) << owner : '0;
    assign mul_out_rdy = active && resp_rdy[owner];
    assign resp_msg    = mul_out_msg;
    assign resp_fire   = mul_out_val && mul_out_rdy;

    // a response fire never overlaps an issue: issue is only possible while idle
    always_ff @(posedge clk)
        if (reset) begin
            state <= STATE_IDLE;
            owner <= '0;
            busy  <= 1'b0;
        end else if (issue_fire) begin
            state <= STATE_BUSY;
            owner <= grant_idx;
            busy  <= 1'b1;
        end else if (resp_fire) begin
            state <= STATE_IDLE;
            busy  <= 1'b0;
        end
endmodule

// File: tb/tb_plab2_proc_shared_mul_arbiter.sv
// tb_plab2_proc_shared_mul_arbiter: directed and random checks against a behavioural arbiter model
module tb_plab2_proc_shared_mul_arbiter;
    localparam int N  = 4;
    localparam int MW = 67;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req_val, req_rdy, resp_val, resp_rdy;
    logic [N*MW-1:0] req_msg;
    logic [DW-1:0] resp_msg, mul_out_msg;
    logic mul_in_val, mul_in_rdy, mul_out_val, mul_out_rdy, busy;
    logic [MW-1:0] mul_in_msg;
    logic [IW-1:0] owner;

    int checks = 0;
    int errors = 0;

    int m_busy = 0, m_owner = 0, m_ptr = 0;
    logic [DW-1:0] exp_prod [N];

    bit x_busy = 0;
    int x_cnt = 0;
    logic [DW-1:0] x_res = '0;
    bit rdy_en = 1, spur_en = 0, oneshot = 1, rand_mode = 0;
    int lat = 1;

    int grants[$];
    int r_core[$];
    logic [DW-1:0] r_msg[$];
    logic [N-1:0] r_vec[$];

    always #5 clk = ~clk;

    plab2_proc_shared_mul_arbiter #(.p_num_reqs(N), .p_msg_nbits(MW), .p_data_nbits(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_msg     (req_msg),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_msg    (resp_msg),
        .mul_in_val  (mul_in_val),
        .mul_in_rdy  (mul_in_rdy),
        .mul_in_msg  (mul_in_msg),
        .mul_out_val (mul_out_val),
        .mul_out_rdy (mul_out_rdy),
        .mul_out_msg (mul_out_msg),
        .busy        (busy),
        .owner       (owner)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [MW-1:0] slice(input int i);
        return req_msg[i*MW +: MW];
    endfunction

    function automatic logic [MW-1:0] mk(input logic [31:0] a, input logic [31:0] b);
        return {3'd0, a, b};
    endfunction

    task automatic clr();
        grants.delete();
        r_core.delete();
        r_msg.delete();
        r_vec.delete();
    endtask

    // one clock: compare at negedge, advance model and multiplier at posedge, then drive
    task automatic tick();
        int g, idx;
        bit m_issue, m_resp, x_in, x_out;
        logic [N-1:0] fired, e;
        logic [MW-1:0] s, in_msg;
        @(negedge clk);
        g = first_req(req_val, m_ptr);
        e = '0;
        if (reset) begin
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_mul_in_val", mul_in_val, 0);
            chk("rst_resp_val", resp_val, 0);
            chk("rst_mul_out_rdy", mul_out_rdy, 0);
        end else if (m_busy == 0) begin
            if (g >= 0 && mul_in_rdy) e[g] = 1'b1;
            chk("req_rdy", req_rdy, e);
            chk("mul_in_val", mul_in_val, g >= 0);
            chk("mul_in_msg", mul_in_msg, slice(g >= 0 ? g : 0));
            chk("resp_val_idle", resp_val, 0);
            chk("mul_out_rdy_idle", mul_out_rdy, 0);
            chk("busy_idle", busy, 0);
            chk("owner_idle", owner, m_owner);
        end else begin
            e[m_owner] = mul_out_val;
            chk("req_rdy_busy", req_rdy, 0);
            chk("mul_in_val_busy", mul_in_val, 0);
            chk("resp_val_busy", resp_val, e);
            chk("mul_out_rdy_busy", mul_out_rdy, resp_rdy[m_owner]);
            if (mul_out_val) chk("resp_msg", resp_msg, mul_out_msg);
            chk("busy_busy", busy, 1);
            chk("owner_busy", owner, m_owner);
        end
        m_issue = !reset && m_busy == 0 && g >= 0 && mul_in_rdy;
        m_resp  = !reset && m_busy != 0 && mul_out_val && resp_rdy[m_owner];
        if (m_issue) begin
            s = slice(g);
            exp_prod[g] = s[63:32] * s[31:0];
        end
        if (m_resp) chk("e2e_result", resp_msg, exp_prod[m_owner]);
        x_in  = mul_in_val && mul_in_rdy;
        x_out = mul_out_val && mul_out_rdy;
        in_msg = mul_in_msg;
        fired = req_val & req_rdy;
        if (x_in) begin
            idx = 99;
            for (int i = 0; i < N; i++) if (req_rdy[i]) idx = i;
            grants.push_back(idx);
        end
        for (int i = 0; i < N; i++)
            if (resp_val[i] && resp_rdy[i]) begin
                r_core.push_back(i);
                r_msg.push_back(resp_msg);
                r_vec.push_back(resp_val);
            end
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0;
        end else if (m_issue) begin
            m_busy = 1; m_owner = g; m_ptr = (g + 1) % N;
        end else if (m_resp) m_busy = 0;
        if (reset) x_busy = 0;
        else if (x_in) begin
            x_busy = 1;
            x_cnt = lat >= 0 ? lat : $urandom_range(0, 4);
            x_res = in_msg[63:32] * in_msg[31:0];
        end else if (x_out) x_busy = 0;
        else if (x_busy && x_cnt > 0) x_cnt--;
        #1;
        mul_in_rdy  = !x_busy && (rand_mode ? ($urandom % 4 != 0) : rdy_en);
        mul_out_val = x_busy ? (x_cnt == 0) : (spur_en && $urandom % 6 == 0);
        mul_out_msg = x_busy ? x_res : $urandom;
        if (oneshot) req_val = req_val & ~fired;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (fired[i] || !req_val[i]) begin
                    req_val[i] = ($urandom % 3 == 0);
                    req_msg[i*MW +: MW] = {3'($urandom), $urandom,
                                           ($urandom % 2) ? 32'($urandom_range(0, 100)) : $urandom};
                end else if ($urandom % 20 == 0) req_val[i] = 1'b0;
                resp_rdy[i] = ($urandom % 4 != 0);
            end
            reset = ($urandom % 400 == 0);
        end
    endtask

    task automatic wait_grants(input int n);
        int c = 0;
        while (grants.size() < n && c < 60) begin tick(); c++; end
        chk("grant_timeout", grants.size() >= n, 1);
    endtask

    task automatic wait_resps(input int n);
        int c = 0;
        while (r_core.size() < n && c < 80) begin tick(); c++; end
        chk("resp_timeout", r_core.size() >= n, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_val = '0;
        tick();
        reset = 1'b0;
        clr();
    endtask

    initial begin
        int eg[5];
        int c;
        reset = 1'b1;
        req_val = '0;
        req_msg = '0;
        resp_rdy = '1;
        mul_in_rdy = 1'b1;
        mul_out_val = 1'b0;
        mul_out_msg = '0;

        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("t1_req_rdy", req_rdy, 0);
        chk("t1_resp_val", resp_val, 0);
        chk("t1_mul_in_val", mul_in_val, 0);
        chk("t1_busy", busy, 0);
        chk("t1_owner", owner, 0);

        clr();
        lat = 2;
        req_msg[2*MW +: MW] = mk(7, 6);
        req_val = 4'b0100;
        wait_grants(1);
        #1;
        chk("t2_grant", grants[0], 2);
        chk("t2_busy", busy, 1);
        chk("t2_owner", owner, 2);
        wait_resps(1);
        #1;
        chk("t2_core", r_core[0], 2);
        chk("t2_result", r_msg[0], 42);
        chk("t2_resp_vec", r_vec[0], 4'b0100);
        chk("t2_busy_after", busy, 0);

        do_reset();
        oneshot = 0;
        lat = 1;
        for (int i = 0; i < N; i++) req_msg[i*MW +: MW] = mk(i + 1, 10);
        req_val = '1;
        wait_resps(5);
        eg = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_grant%0d", k), grants[k], eg[k]);
            chk($sformatf("t3_core%0d", k), r_core[k], eg[k]);
            chk($sformatf("t3_result%0d", k), r_msg[k], 10 * (eg[k] + 1));
        end

        oneshot = 1;
        do_reset();
        resp_rdy = 4'b1101;
        req_msg[1*MW +: MW] = mk(3, 5);
        req_val = 4'b0010;
        wait_grants(1);
        chk("t4_grant0", grants[0], 1);
        req_msg[0*MW +: MW] = mk(9, 9);
        req_val[0] = 1'b1;
        c = 0;
        while (!mul_out_val && c < 20) begin tick(); c++; end
        chk("t4_out_timeout", mul_out_val, 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_resp_val_held", resp_val, 4'b0010);
            chk("t4_resp_msg_held", resp_msg, 15);
            chk("t4_mul_out_rdy", mul_out_rdy, 0);
            chk("t4_req_rdy0", req_rdy[0], 0);
            tick();
        end
        resp_rdy = '1;
        wait_resps(1);
        chk("t4_core0", r_core[0], 1);
        chk("t4_result0", r_msg[0], 15);
        wait_grants(2);
        chk("t4_grant1", grants[1], 0);
        wait_resps(2);
        chk("t4_core1", r_core[1], 0);
        chk("t4_result1", r_msg[1], 81);

        do_reset();
        lat = 3;
        req_msg[3*MW +: MW] = mk(32'hFFFF, 2);
        req_val = 4'b1000;
        wait_grants(1);
        chk("t5_grant0", grants[0], 3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_owner", owner, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("t5_no_stale", r_core.size(), 0);
        req_msg[0*MW +: MW] = mk(5, 5);
        req_val = 4'b1001;
        wait_resps(2);
        chk("t5_grant1", grants[1], 0);
        chk("t5_grant2", grants[2], 3);
        chk("t5_core0", r_core[0], 0);
        chk("t5_result0", r_msg[0], 25);
        chk("t5_core1", r_core[1], 3);
        chk("t5_result1", r_msg[1], 32'h1FFFE);

        do_reset();
        lat = 0;
        req_msg[2*MW +: MW] = mk(2, 3);
        req_val = 4'b0100;
        wait_resps(1);
        req_msg[3*MW +: MW] = mk(4, 4);
        req_msg[0*MW +: MW] = mk(1, 1);
        req_val = 4'b1001;
        wait_resps(3);
        req_msg[0*MW +: MW] = mk(2, 2);
        req_msg[1*MW +: MW] = mk(3, 3);
        req_val = 4'b0011;
        wait_resps(5);
        eg = '{2, 3, 0, 1, 0};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t6_grant%0d", k), grants[k], eg[k]);
            chk($sformatf("t6_core%0d", k), r_core[k], eg[k]);
        end
        chk("t6_result1", r_msg[1], 16);
        chk("t6_result3", r_msg[3], 9);
        chk("t6_result4", r_msg[4], 4);

        do_reset();
        oneshot = 0;
        lat = -1;
        spur_en = 1;
        rand_mode = 1;
        repeat (4000) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
